i4001_rom_arbiter: RTL and testbench

Initiator side of the shared ROM bus: collects fetch requests from up to NUM_PORTS i4001 chip instances and issues them onto the single rom_addr / rom_data bus of the shared ROM storage block. One fetch issued per cycle, fully pipelined, matched to the ROM's one-cycle synchronous read. Each returned byte is routed back to the port that asked for it. Sits between the i4001 chip models and the shared ROM storage instance.

---
 rtl/i4001_rom_arbiter_if.sv | 36 +++
 rtl/i4001_rom_arbiter.sv | 131 +++++++++++++
 tb/tb_i4001_rom_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/i4001_rom_arbiter_if.sv
// Shared-ROM fetch bus between the i4001 chip ports / ROM storage (master) and the arbiter (slave).
// req_* and resp_* are per-port vectors; rom_addr/rom_data face the single shared ROM.
interface i4001_rom_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4
);
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic [NUM_PORTS-1:0]    req_valid;
    logic [AW*NUM_PORTS-1:0] req_addr;
    logic [NUM_PORTS-1:0]    req_ready;
    logic [NUM_PORTS-1:0]    resp_valid;
    logic [DW*NUM_PORTS-1:0] resp_data;
    logic [AW-1:0]           rom_addr;
    logic [DW-1:0]           rom_data;

    modport master (
        output req_valid,
        output req_addr,
        output rom_data,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  rom_addr
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  rom_data,
        output req_ready,
        output resp_valid,
        output resp_data,
        output rom_addr
    );
endinterface

// File: rtl/i4001_rom_arbiter.sv
// i4001 shared-ROM initiator: arbitrates NUM_PORTS fetch ports onto one pipelined ROM bus.
// Build macro I4001_ROM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 highest) instead of round-robin.
module i4001_rom_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PTR_W     = 3
) (
    input logic                sysclk,
    input logic                poc,
    i4001_rom_arbiter_if.slave bus
);
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [NUM_PORTS-1:0]    grant;
    logic                    gnt_any;
    logic [PTR_W-1:0]        gnt_idx;
    logic [AW-1:0]           gnt_addr;

    logic                    a_vld;
    logic [PTR_W-1:0]        a_port;
    logic                    b_vld;
    logic [PTR_W-1:0]        b_port;
    logic [AW-1:0]           rom_addr_q;
    logic [NUM_PORTS-1:0]    resp_valid_q;
    logic [DW*NUM_PORTS-1:0] resp_data_q;

`ifdef I4001_ROM_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins; no fairness state.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!poc) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (!gnt_any && bus.req_valid[i]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = PTR_W'(i);
                    grant[i] = 1'b1;
                end
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;
    logic [SUM_W-1:0] cand;
    logic [SUM_W-1:0] nxt_sum;

    // Search from rr_ptr upward, wrapping modulo NUM_PORTS; extra sum bit keeps NUM_PORTS=2**PTR_W exact.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!poc) begin
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                cand = {1'b0, rr_ptr} + SUM_W'(k);
                if (cand >= SUM_W'(NUM_PORTS)) begin
                    cand = cand - SUM_W'(NUM_PORTS);
                end
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                    if (!gnt_any && (cand == SUM_W'(i)) && bus.req_valid[i]) begin
                        gnt_any  = 1'b1;
                        gnt_idx  = PTR_W'(i);
                        grant[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        nxt_sum = {1'b0, gnt_idx} + SUM_W'(1);
        if (nxt_sum >= SUM_W'(NUM_PORTS)) begin
            nxt_sum = nxt_sum - SUM_W'(NUM_PORTS);
        end
        rr_next = nxt_sum[PTR_W-1:0];
    end

    always_ff @(posedge sysclk) begin
        if (poc) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= rr_next;
        end
    end
`endif

    // Granted port's address; one-hot grant so at most one term is selected.
    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant[i]) begin
                gnt_addr = bus.req_addr[AW*i +: AW];
            end
        end
    end

    // Three-stage fetch pipeline: issue address, ROM read, route byte to requester.
    always_ff @(posedge sysclk) begin
        if (poc) begin
            rom_addr_q   <= '0;
            a_vld        <= 1'b0;
            a_port       <= '0;
            b_vld        <= 1'b0;
            b_port       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            a_vld  <= gnt_any;
            a_port <= gnt_idx;
            if (gnt_any) begin
                rom_addr_q <= gnt_addr;
            end
            b_vld  <= a_vld;
            b_port <= a_port;
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                resp_valid_q[i] <= b_vld && (b_port == PTR_W'(i));
                if (b_vld && (b_port == PTR_W'(i))) begin
                    resp_data_q[DW*i +: DW] <= bus.rom_data;
                end
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_i4001_rom_arbiter.sv
// Directed bench for i4001_rom_arbiter with a one-cycle synchronous ROM model.
// Covers round-robin by default, fixed priority when I4001_ROM_ARB_FIXED_PRIO_EN is defined.
module tb_i4001_rom_arbiter;
    localparam int unsigned NP = 4;

    logic sysclk;
    logic poc;
    int   errors;
    int   checks;

    i4001_rom_arbiter_if #(.NUM_PORTS(NP)) bus ();

    i4001_rom_arbiter #(.NUM_PORTS(NP), .PTR_W(3)) dut (
        .sysclk (sysclk),
        .poc    (poc),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    function automatic logic [7:0] rom_word(input logic [11:0] a);
        if (a == 12'h123) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    // Synchronous ROM: word appears one edge after rom_addr is sampled.
    always @(posedge sysclk) bus.rom_data <= rom_word(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rdata(input int p);
        logic [31:0] all;
        all = bus.resp_data;
        return all[8*p +: 8];
    endfunction

    task automatic set_addr(input int p, input logic [11:0] a);
        bus.req_addr[12*p +: 12] = a;
    endtask

    task automatic pulse_reset();
        poc = 1'b1;
        bus.req_valid = '0;
        @(negedge sysclk);
        poc = 1'b0;
    endtask

    logic [11:0] ports_addr [NP];
    int          order [6];

    initial begin
        errors = 0;
        checks = 0;
        bus.req_valid = 4'b1111;
        bus.req_addr  = '0;

        // Reset with all ports requesting
        poc = 1'b1;
        ports_addr = '{12'h010, 12'h020, 12'h030, 12'h040};
        for (int p = 0; p < int'(NP); p++) set_addr(p, ports_addr[p]);
        for (int r = 0; r < 3; r++) begin
            @(negedge sysclk);
            #1;
            check("rst_ready", 32'(bus.req_ready), 32'h0);
            check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
            check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        end
        @(negedge sysclk);
        poc = 1'b0;
        #1;
        check("post_rst_first_grant", 32'(bus.req_ready), 32'h1);
        check("rst_resp_data", 32'(bus.resp_data), 32'h0);
        bus.req_valid = '0;

        // Single fetch from port 2
        @(negedge sysclk);
        bus.req_valid = 4'b0100;
        set_addr(2, 12'h123);
        #1;
        check("single_ready", 32'(bus.req_ready), 32'h4);
        @(negedge sysclk);
        bus.req_valid = '0;
        #1;
        check("single_rom_addr", 32'(bus.rom_addr), 32'h123);
        check("single_no_early_resp1", 32'(bus.resp_valid), 32'h0);
        @(negedge sysclk);
        #1;
        check("single_no_early_resp2", 32'(bus.resp_valid), 32'h0);
        @(negedge sysclk);
        #1;
        check("single_resp_valid", 32'(bus.resp_valid), 32'h4);
        check("single_resp_data", 32'(rdata(2)), 32'hA5);
        check("single_others_idle", 32'(bus.resp_data) & 32'hFF00FFFF, 32'h0);
        @(negedge sysclk);
        #1;
        check("single_pulse_ends", 32'(bus.resp_valid), 32'h0);
        check("single_data_holds", 32'(rdata(2)), 32'hA5);

        pulse_reset();
        for (int p = 0; p < int'(NP); p++) set_addr(p, ports_addr[p]);

`ifndef I4001_ROM_ARB_FIXED_PRIO_EN
        // Round-robin with all four ports requesting continuously
        order = '{0, 1, 2, 3, 0, 1};
        for (int c = 0; c < 10; c++) begin
            @(negedge sysclk);
            bus.req_valid = (c < 6) ? 4'b1111 : 4'b0000;
            #1;
            check("rr_ready", 32'(bus.req_ready), (c < 6) ? (32'h1 << order[c]) : 32'h0);
            if (c >= 1 && c <= 6)
                check("rr_rom_addr", 32'(bus.rom_addr), 32'(ports_addr[order[c-1]]));
            if (c >= 3 && c <= 8) begin
                check("rr_resp_valid", 32'(bus.resp_valid), 32'h1 << order[c-3]);
                check("rr_resp_data", 32'(rdata(order[c-3])), 32'(rom_word(ports_addr[order[c-3]])));
            end else begin
                check("rr_resp_idle", 32'(bus.resp_valid), 32'h0);
            end
        end
`else
        // Fixed priority: port 0 starves port 3 until it drops
        set_addr(0, 12'h055);
        set_addr(3, 12'h066);
        for (int c = 0; c < 9; c++) begin
            @(negedge sysclk);
            bus.req_valid = (c < 4) ? 4'b1001 : ((c == 4) ? 4'b1000 : 4'b0000);
            #1;
            check("fp_ready", 32'(bus.req_ready), (c < 4) ? 32'h1 : ((c == 4) ? 32'h8 : 32'h0));
            if (c >= 3 && c <= 6) begin
                check("fp_resp_valid0", 32'(bus.resp_valid), 32'h1);
                check("fp_resp_data0", 32'(rdata(0)), 32'(rom_word(12'h055)));
            end else if (c == 7) begin
                check("fp_resp_valid3", 32'(bus.resp_valid), 32'h8);
                check("fp_resp_data3", 32'(rdata(3)), 32'(rom_word(12'h066)));
            end else begin
                check("fp_resp_idle", 32'(bus.resp_valid), 32'h0);
            end
        end
`endif

        // Streaming eight addresses from port 1
        for (int c = 0; c < 12; c++) begin
            @(negedge sysclk);
            bus.req_valid = (c < 8) ? 4'b0010 : 4'b0000;
            set_addr(1, 12'(c));
            #1;
            check("stream_ready", 32'(bus.req_ready), (c < 8) ? 32'h2 : 32'h0);
            if (c >= 1 && c <= 8)
                check("stream_rom_addr", 32'(bus.rom_addr), 32'(c - 1));
            if (c >= 3 && c <= 10) begin
                check("stream_resp_valid", 32'(bus.resp_valid), 32'h2);
                check("stream_resp_data", 32'(rdata(1)), 32'(rom_word(12'(c - 3))));
            end else begin
                check("stream_resp_idle", 32'(bus.resp_valid), 32'h0);
            end
        end

        // Reset lands while a port-3 fetch is in flight
        @(negedge sysclk);
        bus.req_valid = 4'b1000;
        set_addr(3, 12'h0AB);
        #1;
        check("mid_ready", 32'(bus.req_ready), 32'h8);
        @(negedge sysclk);
        poc = 1'b1;
        bus.req_valid = '0;
        #1;
        check("mid_rom_addr", 32'(bus.rom_addr), 32'h0AB);
        check("mid_ready_in_rst", 32'(bus.req_ready), 32'h0);
        @(negedge sysclk);
        poc = 1'b0;
        #1;
        check("mid_rom_addr_clr", 32'(bus.rom_addr), 32'h0);
        check("mid_resp_data_clr", 32'(bus.resp_data), 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge sysclk);
            #1;
            check("mid_no_resp", 32'(bus.resp_valid), 32'h0);
            check("mid_data3_zero", 32'(rdata(3)), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
